dmem_responder: RTL and testbench

Data-memory responder for the pipelined MIPS core. It serves the core's load/store requests, issued as `MemRead`/`MemWrite` from the MEM stage, with a configurable number of wait states. It holds `stall` high while an access is in progress, so the hazard logic freezes the pipeline. It replaces the ideal single-cycle data memory when modelling realistic memory latency.

---
 rtl/mem_pkg.sv | 6 +
 rtl/dmem_array.sv | 23 ++
 rtl/dmem_responder.sv | 71 +++++++
 tb/tb_dmem_responder.sv | 111 +++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the data-memory responder
package mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam int WORD_W = 32;
  localparam int MAX_LATENCY = 15;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port word storage with a registered read port
module dmem_array #(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] widx,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] ridx,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [2**ADDR_W];
  // storage is never cleared by reset
  always_ff @(posedge clk)
    if (we) mem[widx] <= wdata;
  // read register clears on reset and otherwise holds until the next read
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[ridx];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: load/store responder with configurable wait states and stall
module dmem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [31:0]       address,
  input  logic [WORD_W-1:0] write_data,
  output logic [WORD_W-1:0] read_data,
  output logic              stall,
  output logic              mem_err
);
  if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
    $fatal(1, "dmem_responder: LATENCY %0d outside 1..%0d", LATENCY, MAX_LATENCY);
  end
  localparam logic [3:0] CNT_INIT = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
  dmem_state_t state, nxt;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] idx_q;
  logic [WORD_W-1:0] data_q;
  logic wr_q, err_q;
  logic req, accept, re, we;
  logic [ADDR_W-1:0] ridx;
  logic unused_hi;
  assign unused_hi = ^address[31:ADDR_W+2];
  assign req = MemRead | MemWrite;
  assign accept = state == IDLE && req;
  // next state, stall and the one-cycle error pulse in RESP
  always_comb begin
    nxt = state == IDLE ? (req ? (LATENCY == 1 ? RESP : WAIT) : IDLE)
        : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
    stall = accept || state == WAIT;
    mem_err = state == RESP && err_q;
  end
  // a read is captured on the edge entering RESP; at LATENCY 1 that edge is the accept edge
  assign re = nxt == RESP && !(state == IDLE ? MemWrite : wr_q);
  assign ridx = state == IDLE ? address[ADDR_W+1:2] : idx_q;
  assign we = state == RESP && wr_q && !rst;
  // state register and wait counter
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= accept ? CNT_INIT : (state == WAIT && cnt != 4'd0) ? cnt - 4'd1 : cnt;
    end
  // request latches; both-high is a write, and misalignment or both-high flags an error
  always_ff @(posedge clk)
    if (accept) begin
      idx_q <= address[ADDR_W+1:2];
      data_q <= write_data;
      wr_q <= MemWrite;
      err_q <= (MemRead & MemWrite) | (address[1:0] != 2'b00);
    end
  dmem_array #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) u_array (
    .clk(clk),
    .rst(rst),
    .we(we),
    .widx(idx_q),
    .wdata(data_q),
    .re(re),
    .ridx(ridx),
    .rdata(read_data)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of three responders (LATENCY 1,2,3)
module tb_dmem_responder;
  logic clk = 0, rst = 1;
  logic mr [3], mw [3];
  logic [31:0] addr [3], wd [3], rd [3];
  logic st [3], er [3];
  logic [31:0] mdl [3][1024];
  bit known [3][1024];
  logic [31:0] last [3];
  bit last_ok [3];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  dmem_responder #(.ADDR_W(10), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst), .MemRead(mr[0]), .MemWrite(mw[0]),
    .address(addr[0]), .write_data(wd[0]), .read_data(rd[0]), .stall(st[0]), .mem_err(er[0]));
  dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst), .MemRead(mr[1]), .MemWrite(mw[1]),
    .address(addr[1]), .write_data(wd[1]), .read_data(rd[1]), .stall(st[1]), .mem_err(er[1]));
  dmem_responder #(.ADDR_W(10), .LATENCY(3)) u_l3 (.clk(clk), .rst(rst), .MemRead(mr[2]), .MemWrite(mw[2]),
    .address(addr[2]), .write_data(wd[2]), .read_data(rd[2]), .stall(st[2]), .mem_err(er[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask
  // one access on responder k (latency k+1): LATENCY stall cycles, then RESP
  task automatic access(input int k, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    int l = k + 1;
    int i = int'(a[11:2]);
    logic e = (r & w) | (a[1:0] != 2'b00);
    mr[k] = r; mw[k] = w; addr[k] = a; wd[k] = d;
    if (!w) begin
      last_ok[k] = known[k][i];
      last[k] = mdl[k][i];
    end
    for (int c = 0; c <= l; c++) begin
      @(negedge clk);
      chk($sformatf("stall[L%0d c%0d]", l, c), 32'(st[k]), 32'(c < l));
      chk($sformatf("mem_err[L%0d c%0d]", l, c), 32'(er[k]), 32'(c == l && e));
      if (c == l && last_ok[k]) chk($sformatf("read_data[L%0d]", l), rd[k], last[k]);
      @(posedge clk); #1;
    end
    if (w) begin
      mdl[k][i] = d;
      known[k][i] = 1;
    end
    mr[k] = 0; mw[k] = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      last[k] = 0;
      last_ok[k] = 1;
    end
  endtask
  initial begin
    for (int k = 0; k < 3; k++) begin
      mr[k] = 0; mw[k] = 0; addr[k] = 0; wd[k] = 0;
      last[k] = 0; last_ok[k] = 1;
      for (int j = 0; j < 1024; j++) known[k][j] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset stall", 32'(st[k]), 0);
      chk("reset mem_err", 32'(er[k]), 0);
      chk("reset read_data", rd[k], 0);
    end
    @(posedge clk); #1;
    access(1, 0, 1, 32'h40, 32'hDEADBEEF);
    access(1, 1, 0, 32'h40, 0);
    for (int j = 0; j < 4; j++) access(0, 0, 1, 32'(4 * j), 32'(j + 1));
    for (int j = 0; j < 4; j++) access(0, 1, 0, 32'(4 * j), 0);
    access(1, 0, 1, 32'h40, 32'h55);
    access(1, 1, 0, 32'h42, 0);
    access(1, 1, 1, 32'h10, 32'h7);
    access(1, 1, 0, 32'h10, 0);
    access(1, 0, 1, 32'h1000, 32'hA5);
    access(1, 1, 0, 32'h0, 0);
    access(2, 0, 1, 32'h20, 32'h1234);
    mr[2] = 0; mw[2] = 1; addr[2] = 32'h20; wd[2] = 32'h9;
    @(negedge clk);
    chk("rst-test accept stall", 32'(st[2]), 1);
    @(posedge clk); #1;
    mw[2] = 0;
    do_reset();
    @(negedge clk);
    chk("rst-test stall after reset", 32'(st[2]), 0);
    for (int k = 0; k < 3; k++) chk("rst-test read_data cleared", rd[k], 0);
    @(posedge clk); #1;
    access(2, 1, 0, 32'h20, 0);
    for (int n = 0; n < 300; n++) begin
      int k = $urandom_range(0, 2);
      logic w = $urandom_range(0, 1) == 1;
      logic r = w ? $urandom_range(0, 4) == 0 : 1'b1;
      logic [31:0] a = $urandom();
      a[11:2] = 10'(10'h100 + $urandom_range(0, 15));
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      access(k, r, w, a, $urandom());
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("idle stall", 32'(st[k]), 0);
        chk("idle mem_err", 32'(er[k]), 0);
        @(posedge clk); #1;
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
